// File: rtl/multdiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : multdiv_sequencer
// Description : Launches the shared multiplier/divider, times its fixed
//               latency, then writes HI/LO or raises a divide-by-zero exception.
// Revision    : 1.0 - initial release
// ============================================================================
module multdiv_sequencer #(
  parameter int MULT_CYCLES = 33,
  parameter int DIV_CYCLES  = 35
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  output logic        mult_control,
  output logic        div_control,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  input  logic        zero_div,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        hilo_write,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc
);

  localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int c_CNT_W      = $clog2(c_MAX_CYCLES) + 1;
  localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_WAIT   = 3'd2,
    S_WRITE  = 3'd3,
    S_EXC    = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic               r_op;
  logic               w_op_next;
  logic               w_accept;
  logic [c_CNT_W-1:0] r_count;

  logic        r_mult_control;
  logic        r_div_control;
  logic        r_hilo_write;
  logic        r_busy;
  logic        r_div_zero_exc;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  // WRITE also samples start so a held request relaunches with no idle gap.
  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    w_accept     = 1'b0;
    unique case (r_state)
      S_IDLE:   w_accept = start;
      S_LAUNCH: w_state_next = S_WAIT;
      S_WAIT: begin
        if (r_op && zero_div) begin
          w_state_next = S_EXC;
        end else if (r_count == '0) begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        w_state_next = S_IDLE;
        w_accept     = start;
      end
      S_EXC:    w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
    if (w_accept) begin
      w_state_next = S_LAUNCH;
      w_op_next    = op;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_op           <= 1'b0;
      r_count        <= '0;
      r_mult_control <= 1'b0;
      r_div_control  <= 1'b0;
      r_hilo_write   <= 1'b0;
      r_busy         <= 1'b0;
      r_div_zero_exc <= 1'b0;
      r_hi           <= '0;
      r_lo           <= '0;
    end else begin
      r_state <= w_state_next;
      r_op    <= w_op_next;

      if (r_state == S_LAUNCH) begin
        r_count <= r_op ? c_DIV_LOAD : c_MULT_LOAD;
      end else if (r_state == S_WAIT && r_count != '0) begin
        r_count <= r_count - c_CNT_ONE;
      end

      if (r_state == S_WAIT && w_state_next == S_WRITE) begin
        r_hi <= r_op ? div_hi : mult_hi;
        r_lo <= r_op ? div_lo : mult_lo;
      end

      r_mult_control <= (w_state_next == S_LAUNCH) && !w_op_next;
      r_div_control  <= (w_state_next == S_LAUNCH) &&  w_op_next;
      r_hilo_write   <= (w_state_next == S_WRITE);
      r_div_zero_exc <= (w_state_next == S_EXC);
      r_busy         <= (w_state_next != S_IDLE);
    end
  end

  assign mult_control = r_mult_control;
  assign div_control  = r_div_control;
  assign hilo_write   = r_hilo_write;
  assign done         = r_hilo_write;
  assign busy         = r_busy;
  assign div_zero_exc = r_div_zero_exc;
  assign hi_out       = r_hi;
  assign lo_out       = r_lo;

endmodule
`default_nettype wire
